// File: rtl/load_sample_buffer_pkg.sv
// Shared constants for the load-strobe path (strobe generator and sample buffer).
// Contents: sample/pointer/counter widths, buffer depth, done threshold,
// buffer mode encoding and the pointer increment helper.
package load_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DONE_COUNT = 320;
  localparam int unsigned CNT_W      = 10;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // PRIME: read pointer still level with write pointer (first strobe only).
  // RUN:   read pointer one ahead of write pointer, buffer acts as delay line.
  typedef enum logic {
    MODE_PRIME = 1'b0,
    MODE_RUN   = 1'b1
  } mode_e;

  // DEPTH is a power of two, so natural overflow gives the ring wrap.
  function automatic addr_t next_addr(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/load_sample_buffer_if.sv
// Bundle of the sample-buffer signals between the strobe/data source and the buffer.
//   en_load    : load strobe level (source -> buffer)
//   data_in    : sample to store on an accepted strobe (source -> buffer)
//   data_out   : delayed sample (buffer -> consumer)
//   data_valid : one-cycle pulse, data_out holds a real sample
//   addr_w     : write pointer
//   addr_r     : read pointer
//   load_cnt   : accepted strobes since reset
//   done       : sticky end-of-run flag
interface load_sample_buffer_if;

  logic                         en_load;
  logic [load_pkg::DATA_W-1:0]  data_in;
  logic [load_pkg::DATA_W-1:0]  data_out;
  logic                         data_valid;
  logic [load_pkg::ADDR_W-1:0]  addr_w;
  logic [load_pkg::ADDR_W-1:0]  addr_r;
  logic [load_pkg::CNT_W-1:0]   load_cnt;
  logic                         done;

  modport master (
    output en_load, data_in,
    input  data_out, data_valid, addr_w, addr_r, load_cnt, done
  );

  modport slave (
    input  en_load, data_in,
    output data_out, data_valid, addr_w, addr_r, load_cnt, done
  );

endinterface

// File: rtl/load_sample_buffer_mem.sv
// sample_mem: DEPTH x DATA_W storage, one synchronous write port and one
// asynchronous read port. A read and write to the same address in one cycle
// returns the old contents (read-before-write). No reset on the array.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module sample_mem
  import load_pkg::*;
(
  input  logic    clk,
  input  logic    we,
  input  addr_t   waddr,
  input  sample_t wdata,
  input  addr_t   raddr,
  output sample_t rdata
);

  sample_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/load_sample_buffer.sv
// load_sample_buffer: consumer end of the load-strobe interface.
// Captures data_in on each falling edge of en_load into a ring buffer and
// returns the sample written 15 strobes earlier, stopping after DONE_COUNT
// accepted strobes.
//   clk : clock, all state on posedge
//   rst : asynchronous active-low reset
//   bus : load_sample_buffer_if.slave (en_load, data_in in; data_out,
//         data_valid, addr_w, addr_r, load_cnt, done out)
module load_sample_buffer
  import load_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  load_sample_buffer_if.slave  bus
);

  logic    en_load_q;
  addr_t   addr_w;
  addr_t   addr_r;
  cnt_t    load_cnt;
  sample_t data_out;
  logic    data_valid;
  logic    done;

  logic    strobe;
  logic    accepted;
  mode_e   mode;
  sample_t rd_data;

  // en_load_q resets low, so a low en_load right after reset is not a fall.
  assign strobe   = en_load_q & ~bus.en_load;
  assign accepted = strobe & ~done;

  always_comb begin
    mode = MODE_RUN;
    if (addr_w == addr_r) begin
      mode = MODE_PRIME;
    end
  end

  sample_mem u_mem (
    .clk   (clk),
    .we    (accepted),
    .waddr (addr_w),
    .wdata (bus.data_in),
    .raddr (addr_r),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_load_q  <= 1'b0;
      addr_w     <= '0;
      addr_r     <= '0;
      load_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      en_load_q  <= bus.en_load;
      data_valid <= 1'b0;
      if (accepted) begin
        if (mode == MODE_PRIME) begin
          addr_r <= next_addr(addr_r);
        end else begin
          addr_w   <= next_addr(addr_w);
          addr_r   <= next_addr(addr_r);
          data_out <= rd_data;
          // Slots are only trusted once every entry has been written since reset.
          data_valid <= (load_cnt >= cnt_t'(DEPTH));
        end
        if (load_cnt != cnt_t'(DONE_COUNT)) begin
          load_cnt <= load_cnt + cnt_t'(1);
        end
        if (load_cnt == cnt_t'(DONE_COUNT - 1)) begin
          done <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.addr_w     = addr_w;
  assign bus.addr_r     = addr_r;
  assign bus.load_cnt   = load_cnt;
  assign bus.done       = done;

endmodule

// File: tb/tb_load_sample_buffer.sv
module tb_load_sample_buffer;

  logic clk;
  logic rst;

  load_sample_buffer_if bus ();

  load_sample_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_failed;

  // reference model state
  int m_k;
  bit m_done;
  int m_aw;
  int m_ar;
  int m_valid;
  int m_dout;
  bit m_known;
  int hist [0:399];

  typedef struct {
    int idx;
    int aw;
    int ar;
    int cnt;
    int valid;
    int dout;
    bit chk_dout;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0;
    m_done = 1'b0;
    m_aw = 0;
    m_ar = 0;
    m_valid = 0;
    m_dout = 0;
    m_known = 1'b1;
  endtask

  task automatic model_step(input int d);
    m_valid = 0;
    if (!m_done) begin
      hist[m_k] = d;
      if (m_k == 0) begin
        m_aw = 0;
        m_ar = 1;
      end else begin
        m_aw = m_k % 16;
        m_ar = (m_k + 1) % 16;
        if (m_k >= 16) begin
          m_valid = 1;
          m_dout = hist[m_k - 15];
          m_known = 1'b1;
        end else begin
          m_known = 1'b0;
        end
      end
      m_k++;
      if (m_k == 320) m_done = 1'b1;
    end
  endtask

  task automatic model_check();
    chk("addr_w", int'(bus.addr_w), m_aw);
    chk("addr_r", int'(bus.addr_r), m_ar);
    chk("load_cnt", int'(bus.load_cnt), m_k);
    chk("data_valid", int'(bus.data_valid), m_valid);
    chk("done", int'(bus.done), int'(m_done));
    if (m_known) chk("data_out", int'(bus.data_out), m_dout);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr_w"}, int'(bus.addr_w), 0);
    chk({tag, "_addr_r"}, int'(bus.addr_r), 0);
    chk({tag, "_load_cnt"}, int'(bus.load_cnt), 0);
    chk({tag, "_data_out"}, int'(bus.data_out), 0);
    chk({tag, "_data_valid"}, int'(bus.data_valid), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  // en_load high for hi clocks, then low for lo clocks; the fall is seen at
  // the first low posedge, where the model is checked.
  task automatic run_strobe(input int d, input int hi, input int lo);
    @(negedge clk);
    bus.en_load = 1'b1;
    bus.data_in = 16'(d);
    repeat (hi) @(negedge clk);
    bus.en_load = 1'b0;
    @(posedge clk);
    #1;
    model_step(d);
    model_check();
    if (lo > 1) begin
      @(posedge clk);
      #1;
      chk("valid_width", int'(bus.data_valid), 0);
      repeat (lo - 2) @(posedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_failed = 0;
    tbl[0] = '{idx: 0,  aw: 0,  ar: 1, cnt: 1,  valid: 0, dout: 0, chk_dout: 1'b1};
    tbl[1] = '{idx: 1,  aw: 1,  ar: 2, cnt: 2,  valid: 0, dout: 0, chk_dout: 1'b0};
    tbl[2] = '{idx: 2,  aw: 2,  ar: 3, cnt: 3,  valid: 0, dout: 0, chk_dout: 1'b0};
    tbl[3] = '{idx: 14, aw: 14, ar: 15, cnt: 15, valid: 0, dout: 0, chk_dout: 1'b0};
    tbl[4] = '{idx: 15, aw: 15, ar: 0, cnt: 16, valid: 0, dout: 0, chk_dout: 1'b0};
    tbl[5] = '{idx: 16, aw: 0,  ar: 1, cnt: 17, valid: 1, dout: 1, chk_dout: 1'b1};
    tbl[6] = '{idx: 17, aw: 1,  ar: 2, cnt: 18, valid: 1, dout: 2, chk_dout: 1'b1};

    rst = 1'b0;
    bus.en_load = 1'b0;
    bus.data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;

    // test 1: priming and first valid outputs, table checked
    for (int k = 0; k < 18; k++) begin
      run_strobe(k, 2, 6);
      for (int t = 0; t < 7; t++) begin
        if (tbl[t].idx == k) begin
          chk("tbl_addr_w", int'(bus.addr_w), tbl[t].aw);
          chk("tbl_addr_r", int'(bus.addr_r), tbl[t].ar);
          chk("tbl_load_cnt", int'(bus.load_cnt), tbl[t].cnt);
          if (tbl[t].chk_dout) chk("tbl_data_out", int'(bus.data_out), tbl[t].dout);
        end
      end
    end

    // test 2: pointer wrap, delay relation
    for (int k = 18; k < 40; k++) run_strobe(k, 2, 6);

    // test 3: done at 320 accepted strobes, later strobes ignored
    for (int k = 40; k < 325; k++) run_strobe(k, 2, 2);
    chk("done_final", int'(bus.done), 1);
    chk("cnt_final", int'(bus.load_cnt), 320);

    // test 4: reset mid-run with en_load high
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 100; k++) run_strobe(1000 + k, 1, 1);
    @(negedge clk);
    bus.en_load = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) run_strobe(k, 1, 3);

    // test 5: en_load low across reset release gives no strobe
    @(negedge clk);
    bus.en_load = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset_vals("release");
    run_strobe(171, 1, 3);
    repeat (5) @(posedge clk);
    #1;
    chk("single_strobe_cnt", int'(bus.load_cnt), 1);

    // test 6: back-to-back strobes, period 2
    for (int k = 1; k < 21; k++) run_strobe(100 + k, 1, 1);
    @(posedge clk);
    #1;
    chk("b2b_cnt", int'(bus.load_cnt), 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
